// File: rtl/hud_data_ctrl.sv
// hud_data_ctrl: buffers HUD producer updates in shadow registers and commits them to the
// renderer only at frame start, forcing attention/meditation to 0 when the headset stalls.
module hud_data_ctrl #(
    parameter int STALE_FRAMES = 120,
    parameter int SCORE_MAX    = 7
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       att_valid,
    input  logic [7:0] att_in,
    input  logic       med_valid,
    input  logic [7:0] med_in,
    input  logic       sig_valid,
    input  logic [7:0] sig_in,
    input  logic       eat,
    input  logic       game_clear,
    output logic [2:0] score,
    output logic [7:0] attention_data,
    output logic [7:0] meditation_data,
    output logic [7:0] signal_data,
    output logic       data_stale,
    output logic       commit
);
    typedef enum logic {IDLE, COMMIT} state_t;

    localparam logic [7:0] STALE_MAX = 8'(STALE_FRAMES);
    localparam logic [2:0] SCORE_TOP = 3'(SCORE_MAX);

    state_t     state, state_next;
    logic [7:0] sh_att, sh_med, sh_sig, stale_cnt;
    logic [2:0] sh_score;
    logic [3:0] pending;
    logic       stale_next;

    assign stale_next = (stale_cnt == STALE_MAX);

    always_comb begin
        state_next = IDLE;
        if (state == IDLE)
            state_next = frame_start ? COMMIT : IDLE;
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Strobes landing in the COMMIT cycle keep their pending bit: set beats clear.
    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            sh_att    <= 8'h00;
            sh_med    <= 8'h00;
            sh_sig    <= 8'hC8;
            sh_score  <= 3'd0;
            pending   <= 4'b0000;
            stale_cnt <= STALE_MAX;
        end else begin
            if (att_valid)
                sh_att <= att_in;
            if (med_valid)
                sh_med <= med_in;
            if (sig_valid)
                sh_sig <= sig_in;
            if (game_clear)
                sh_score <= 3'd0;
            else if (eat && sh_score < SCORE_TOP)
                sh_score <= sh_score + 3'd1;
            pending <= ((state == COMMIT) ? 4'b0000 : pending)
                     | {att_valid, med_valid, sig_valid, eat | game_clear};
            if (att_valid || med_valid)
                stale_cnt <= 8'd0;
            else if (frame_start && stale_cnt < STALE_MAX)
                stale_cnt <= stale_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            score           <= 3'd0;
            attention_data  <= 8'h00;
            meditation_data <= 8'h00;
            signal_data     <= 8'hC8;
            data_stale      <= 1'b1;
            commit          <= 1'b0;
        end else begin
            commit <= (state == COMMIT);
            if (state == COMMIT) begin
                score           <= sh_score;
                attention_data  <= stale_next ? 8'h00 : sh_att;
                meditation_data <= stale_next ? 8'h00 : sh_med;
                signal_data     <= sh_sig;
                data_stale      <= stale_next;
            end
        end
    end
endmodule

// File: tb/tb_hud_data_ctrl.sv
// tb_hud_data_ctrl: directed stimulus with a reference model feeding an expected-commit queue;
// every cycle the outputs are checked against the held or newly committed expectation.
module tb_hud_data_ctrl;
    localparam int ST = 120;
    localparam int SM = 7;

    logic       clk_25M = 1'b0, rst = 1'b0;
    logic       frame_start = 0, att_valid = 0, med_valid = 0, sig_valid = 0, eat = 0, game_clear = 0;
    logic [7:0] att_in = 0, med_in = 0, sig_in = 0;
    logic [2:0] score;
    logic [7:0] attention_data, meditation_data, signal_data;
    logic       data_stale, commit;

    hud_data_ctrl #(.STALE_FRAMES(ST), .SCORE_MAX(SM)) dut (
        .clk_25M(clk_25M), .rst(rst), .frame_start(frame_start),
        .att_valid(att_valid), .att_in(att_in), .med_valid(med_valid), .med_in(med_in),
        .sig_valid(sig_valid), .sig_in(sig_in), .eat(eat), .game_clear(game_clear),
        .score(score), .attention_data(attention_data), .meditation_data(meditation_data),
        .signal_data(signal_data), .data_stale(data_stale), .commit(commit)
    );

    always #20 clk_25M = ~clk_25M;

    typedef struct packed {
        logic [2:0] s;
        logic [7:0] a, m, g;
        logic       st;
    } exp_t;

    exp_t       q[$];
    exp_t       held;
    int         total = 0, bad = 0;
    logic [7:0] m_att, m_med, m_sig, m_cnt;
    logic [2:0] m_score;
    logic       m_st;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input exp_t x, input logic c);
        chk("commit", {7'd0, commit}, {7'd0, c});
        chk("score", {5'd0, score}, {5'd0, x.s});
        chk("attention", attention_data, x.a);
        chk("meditation", meditation_data, x.m);
        chk("signal", signal_data, x.g);
        chk("stale", {7'd0, data_stale}, {7'd0, x.st});
    endtask

    task automatic reset_model();
        m_att = 0; m_med = 0; m_sig = 8'hC8; m_score = 0; m_cnt = 8'(ST); m_st = 0;
        q.delete();
        held = '{s: 3'd0, a: 8'h00, m: 8'h00, g: 8'hC8, st: 1'b1};
    endtask

    task automatic step(input logic fs, input logic av, input logic [7:0] ai,
                        input logic mv, input logic [7:0] mi, input logic sv,
                        input logic [7:0] si, input logic e, input logic gc);
        logic was, stl;
        frame_start = fs; att_valid = av; att_in = ai; med_valid = mv; med_in = mi;
        sig_valid = sv; sig_in = si; eat = e; game_clear = gc;
        @(posedge clk_25M);
        #1;
        frame_start = 0; att_valid = 0; med_valid = 0; sig_valid = 0; eat = 0; game_clear = 0;
        was = m_st;
        if (was) begin
            chk("sb_nonempty", {7'd0, q.size() > 0}, 8'd1);
            if (q.size() > 0)
                held = q.pop_front();
        end
        if (av) m_att = ai;
        if (mv) m_med = mi;
        if (sv) m_sig = si;
        if (gc) m_score = 0;
        else if (e && m_score < 3'(SM)) m_score = m_score + 1;
        if (av || mv) m_cnt = 0;
        else if (fs && m_cnt < 8'(ST)) m_cnt = m_cnt + 1;
        m_st = !was && fs;
        if (m_st) begin
            stl = (m_cnt == 8'(ST));
            q.push_back('{s: m_score, a: stl ? 8'h00 : m_att, m: stl ? 8'h00 : m_med, g: m_sig, st: stl});
        end
        check_out(held, was);
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic frame();           step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic att(input logic [7:0] v); step(0, 1, v, 0, 0, 0, 0, 0, 0); endtask
    task automatic med(input logic [7:0] v); step(0, 0, 0, 1, v, 0, 0, 0, 0); endtask
    task automatic frame_idle();      frame(); idle(); endtask

    initial begin
        reset_model();
        repeat (3) @(posedge clk_25M);
        #1;
        check_out(held, 1'b0);
        rst = 1'b1;
        idle();
        frame_idle();
        idle();
        att(8'h5A);
        med(8'h3C);
        step(0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        idle();
        frame_idle();
        att(8'h11);
        att(8'h22);
        frame();
        att(8'h33);
        idle();
        frame_idle();
        repeat (9) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        frame_idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        frame_idle();
        att(8'h9B);
        med(8'h4D);
        for (int i = 0; i < ST; i++) begin
            frame_idle();
            idle();
        end
        chk("stale_reached", {7'd0, data_stale}, 8'd1);
        med(8'h44);
        frame_idle();
        chk("stale_cleared", {7'd0, data_stale}, 8'd0);
        att(8'h77);
        frame();
        #4 rst = 1'b0;
        #1;
        reset_model();
        check_out(held, 1'b0);
        @(posedge clk_25M);
        #1;
        check_out(held, 1'b0);
        rst = 1'b1;
        idle();
        frame_idle();
        idle();
        chk("sb_drained", 8'(q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hud_data_ctrl.md
# hud_data_ctrl

Frame-synchronous update controller for the sidebar HUD. Collects asynchronous-rate producer updates (brainwave parser attention/meditation/signal bytes, game-logic score events) into shadow registers, then commits them to the values driving the HUD renderer only at frame start. This guarantees the renderer never shows a torn digit within a frame. Also detects a stalled headset and forces the attention/meditation digits to 0.

## Interface
Parameters:
- STALE_FRAMES, 120, number of frame_start pulses without att_valid/med_valid before data is declared stale (~2 s at 60 Hz); range 1..255
- SCORE_MAX, 7, saturation value of score (fits the 3-bit display digit)

Ports:
- clk_25M  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at start of vertical blank
- att_valid  in  1  one-cycle strobe, att_in valid
- att_in  in  8  attention byte from parser
- med_valid  in  1  one-cycle strobe, med_in valid
- med_in  in  8  meditation byte from parser
- sig_valid  in  1  one-cycle strobe, sig_in valid
- sig_in  in  8  poor-signal byte from parser (0 = good, 200 = no contact)
- eat  in  1  one-cycle pulse, score +1
- game_clear  in  1  one-cycle pulse, score to 0
- score  out  3  committed score to renderer
- attention_data  out  8  committed attention byte
- meditation_data  out  8  committed meditation byte
- signal_data  out  8  committed signal byte
- data_stale  out  1  committed stale flag
- commit  out  1  one-cycle pulse, high in the cycle the outputs first show new values

## Operation
- Shadow registers sh_att, sh_med, sh_sig, sh_score capture inputs every cycle the matching strobe is high. The latest value wins. Each write sets its pending bit.
- sh_score rules:
  - game_clear loads 0.
  - eat increments, saturating at SCORE_MAX.
  - game_clear and eat in the same cycle gives 0.
- Stale counter (8 bit):
  - Cleared to 0 on any cycle with att_valid or med_valid.
  - Otherwise increments on frame_start, saturating at STALE_FRAMES.
  - stale_next = (counter == STALE_FRAMES).
- FSM with two states:
  - IDLE: on frame_start go to COMMIT; otherwise stay.
  - COMMIT: lasts exactly one cycle, always returns to IDLE.
- Actions on leaving COMMIT (the clock edge ending the COMMIT cycle):
  - All shadows copy to outputs, whether pending or not.
  - data_stale <= stale_next.
  - If stale_next is set, attention_data and meditation_data load 0 instead of their shadows.
  - All pending bits clear.
  - commit asserts for one cycle.
- Strobe coinciding with the COMMIT cycle: shadow takes the new value and pending stays set (set beats clear). The new value appears at the next commit, not the current one.
- frame_start while in COMMIT: ignored.
- Outputs never change except at the commit edge or at reset.

## Timing
- Reset (async assert, sync release):
  - FSM = IDLE
  - score, attention_data, meditation_data = 0
  - signal_data = 8'hC8
  - data_stale = 1, stale counter = STALE_FRAMES
  - shadows equal the output reset values
  - pending = 0, commit = 0
- Latency, strobe to output: frame_start sampled at edge N → COMMIT during cycle N..N+1 → outputs update at edge N+1, commit high N+1..N+2.
  - Worst case is one frame plus 2 cycles.
  - A strobe at edge N itself is included in that commit.
- Reset mid-COMMIT: the update is aborted and all values return to reset values.
- Stale counter saturation: values at and above STALE_FRAMES do not wrap.
- Score saturation: SCORE_MAX plus eat stays at SCORE_MAX. No wrap to 0.

## Test plan
- Reset, then one frame_start with no strobes → commit pulse two edges later; score=0, att=0, med=0, signal_data=8'hC8, data_stale=1 (counter starts saturated).
- att_valid att_in=8'h5A, med_valid med_in=8'h3C, then frame_start → outputs 8'h5A/8'h3C, data_stale=0 at the commit edge. Outputs unchanged on every cycle before it.
- att_valid=8'h11 then att_valid=8'h22 within one frame → only 8'h22 is committed. att_valid=8'h33 in the COMMIT cycle → 8'h22 now, 8'h33 at the following commit.
- 9 eat pulses, then frame_start → score=7. eat and game_clear together, then frame_start → score=0.
- Valid att/med once, then 120 frame_starts with no att/med strobes → at the 120th commit data_stale=1 and att=med=0. Next med_valid plus frame_start → data_stale=0 and values restored.
- Assert rst during the COMMIT cycle with pending att=8'h77 → all outputs at reset values, commit stays 0, FSM IDLE after release.
